tone_arbiter: RTL
=================

Name: tone_arbiter

Overview:
- Parametrised multi-source buzzer engine, successor to the single-purpose alarm buzzer.
- Accepts N_SRC independent level requests. Each source has a run-time beep pattern: tone half-period, on-time, off-time and repeat count.
- A fixed-priority arbiter drives one piezo output. The highest index wins, with pre-emption.
- Sits between the controller FSMs (oven, danger detect, key-click) and the buzzer pin.

Parameters:
- N_SRC, 4, number of request channels; index N_SRC-1 has the highest priority.
- DIV_W, 21, width of tone half-period counts.
- CNT_W, 27, width of on/off phase counts.
- REP_W, 4, width of the repeat count.
- SEL_W, $clog2(N_SRC) (min 1), width of active_src.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  N_SRC  per-source level request
- half_period  input  N_SRC*DIV_W  per-source tone half-period in clk cycles; 0 = silent beep
- on_cycles  input  N_SRC*CNT_W  per-source beep-on length
- off_cycles  input  N_SRC*CNT_W  per-source gap length
- repeat_cnt  input  N_SRC*REP_W  beeps per pattern; 0 = continuous while req held
- mute  input  1  forces buzzer low; timing continues
- buzzer  output  1  registered square-wave output
- busy  output  1  high in ON or OFF state
- active_src  output  SEL_W  index of the source currently being played
- done  output  N_SRC  one-cycle pulse when a source's pattern completes

Behaviour:
- Reset (reset=0, async): buzzer=0, busy=0, active_src=0, done=0, served=0, all counters 0, state IDLE.
- served[i]: set when source i completes; cleared in any cycle with req[i]=0. A completed level request does not replay until req[i] drops and re-rises.
- Eligible: req[i] & ~served[i]. Winner: highest eligible index.
- Config is sampled live each cycle from the active source's slice; no latching.
- States:
  - IDLE: if any source is eligible, next cycle go to ON. Set active_src=winner, phase_cnt=0, beep_cnt=0, tone divider cleared (tone=0).
  - ON: phase_cnt++ each cycle. Divider toggles tone when div_cnt==half_period-1, then div_cnt=0.
    - At phase_cnt==on_cycles-1: go to OFF, phase_cnt=0, beep_cnt++.
  - OFF: tone held 0. At phase_cnt==off_cycles-1:
    - if repeat_cnt!=0 and beep_cnt==repeat_cnt: pulse done[active_src], set served, go to IDLE;
    - otherwise go to ON and clear the divider.
  - on_cycles=0 or off_cycles=0 is treated as 1.
- Pre-emption in ON/OFF:
  - If a higher-index eligible source appears, next cycle restart in ON for that source. Counters and divider are cleared.
  - The pre-empted source is not served and replays from the start when it next wins.
- Abort: if req[active_src] drops in ON/OFF, next cycle go to IDLE (or directly to ON for another eligible winner). No done pulse.
- Simultaneous completion and pre-emption: completion wins. done pulses and served is set, then the higher source starts in the following cycle.
- repeat_cnt=0: beep_cnt saturates and is never compared; the pattern loops while req is held; no done pulse.
- Outputs:
  - buzzer <= (state==ON) & tone & ~mute & (half_period!=0).
  - First toggle after a beep start appears half_period+1 cycles after ON entry.
- busy and active_src are registered with state.

Optional Feature:
- Macro: TONE_ARBITER_TWO_TONE_EN.
- Defined:
  - Adds input alt_half_period (N_SRC*DIV_W) and parameter ALT_CYCLES (default 20_000_000).
  - During ON, the divider target swaps between half_period and alt_half_period every ALT_CYCLES cycles, starting with primary. This gives a siren-style warble.
  - On each swap the divider is cleared; the swap timer is cleared at every ON entry.
  - alt_half_period=0 means the primary tone is held.
- Undefined: the port and parameter are absent; single tone only.

Decomposition:
- Package tone_arbiter_pkg holds:
  - state enum (IDLE/ON/OFF);
  - default constants COUNT_1000HZ=50_000, COUNT_2000HZ=25_000, COUNT_3000HZ=16_667, COUNT_4000HZ=12_500, BEEP_ON_250MS=25_000_000, BEEP_OFF_750MS=75_000_000;
  - default widths.
- Sub-module tone_div: clear, enable, half_period in; tone out. Instantiated once; a second instance is not needed for the two-tone feature.

Test Plan:
- req[0]=1, hp=2, on=8, off=4, rep=2:
  - two beeps, tone toggling every 2 cycles during each ON;
  - done[0] pulses once 24 cycles after ON entry;
  - buzzer stays 0 while req is held;
  - drop req for 1 cycle and raise it again -> the pattern replays.
- req[0] mid-beep, then req[2] rises -> within 1 cycle active_src=2 and the pattern restarts. req[2] completes -> source 0 restarts from beep 1.
- req[1] drops during OFF of beep 1 (rep=3) -> IDLE next cycle, done stays 0, buzzer 0.
- rep=0, on=8, off=4, held 100 cycles -> 8 full beeps plus partial, no done pulse, busy continuously 1.
- reset driven 0 mid-ON -> buzzer 0 asynchronously. After release with req held: restart from beep 1, first toggle at ON entry + hp + 1.
- mute=1 during a rep=2 pattern -> buzzer 0 throughout; done[i] timing identical to the unmuted run.

Source files
------------

// File: rtl/tone_arbiter_pkg.sv
// rtl/tone_arbiter_pkg.sv - shared state type, default widths and tone/beep constants for tone_arbiter
package tone_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int DEF_N_SRC = 4;
    localparam int DEF_DIV_W = 21;
    localparam int DEF_CNT_W = 27;
    localparam int DEF_REP_W = 4;

    // Half-period counts and beep lengths for a 100 MHz clock.
    localparam int COUNT_1000HZ   = 50_000;
    localparam int COUNT_2000HZ   = 25_000;
    localparam int COUNT_3000HZ   = 16_667;
    localparam int COUNT_4000HZ   = 12_500;
    localparam int BEEP_ON_250MS  = 25_000_000;
    localparam int BEEP_OFF_750MS = 75_000_000;

endpackage

// File: rtl/tone_div.sv
// rtl/tone_div.sv - square-wave divider toggling tone every half_period enabled cycles
module tone_div
    import tone_arbiter_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_period,
    output logic             tone
);

    logic [DIV_W-1:0] div_cnt;

    // Count enabled cycles; toggle at the end of each half period. A zero half period never toggles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (clear) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (enable && (half_period != '0)) begin
            if (div_cnt == half_period - DIV_W'(1)) begin
                div_cnt <= '0;
                tone    <= ~tone;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_arbiter.sv
// rtl/tone_arbiter.sv - fixed-priority multi-source beep engine; optional warble under TONE_ARBITER_TWO_TONE_EN
module tone_arbiter
    import tone_arbiter_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W,
    parameter int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
`ifdef TONE_ARBITER_TWO_TONE_EN
    ,
    parameter int ALT_CYCLES = 20_000_000
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*DIV_W-1:0] half_period,
    input  logic [N_SRC*CNT_W-1:0] on_cycles,
    input  logic [N_SRC*CNT_W-1:0] off_cycles,
    input  logic [N_SRC*REP_W-1:0] repeat_cnt,
`ifdef TONE_ARBITER_TWO_TONE_EN
    input  logic [N_SRC*DIV_W-1:0] alt_half_period,
`endif
    input  logic                   mute,
    output logic                   buzzer,
    output logic                   busy,
    output logic [SEL_W-1:0]       active_src,
    output logic [N_SRC-1:0]       done
);

    state_t           state;
    state_t           nstate;
    logic [CNT_W-1:0] phase_cnt;
    logic [REP_W-1:0] beep_cnt;
    logic [N_SRC-1:0] served;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] cmpl_vec;
    logic [SEL_W-1:0] winner;
    logic             any_elig;
    logic [DIV_W-1:0] cur_hp;
    logic [CNT_W-1:0] cur_on;
    logic [CNT_W-1:0] cur_off;
    logic [REP_W-1:0] cur_rep;
    logic             cur_req;
    logic             on_last;
    logic             off_last;
    logic             start_pat;
    logic             next_beep;
    logic             complete;
    logic             div_clear;
    logic [DIV_W-1:0] div_target;
    logic             tone;

    assign elig     = req & ~served;
    assign any_elig = |elig;
    assign busy     = (state != ST_IDLE);

    // Highest eligible index wins; also pick out the active source's live configuration.
    always_comb begin
        winner  = '0;
        cur_hp  = '0;
        cur_on  = '0;
        cur_off = '0;
        cur_rep = '0;
        cur_req = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (elig[i]) begin
                winner = SEL_W'(i);
            end
            if (active_src == SEL_W'(i)) begin
                cur_hp  = half_period[i*DIV_W +: DIV_W];
                cur_on  = on_cycles[i*CNT_W +: CNT_W];
                cur_off = off_cycles[i*CNT_W +: CNT_W];
                cur_rep = repeat_cnt[i*REP_W +: REP_W];
                cur_req = req[i];
            end
        end
    end

    // Zero-length phases behave as one cycle, so the last count is 0 in that case.
    assign on_last  = (phase_cnt == ((cur_on  == '0) ? '0 : cur_on  - CNT_W'(1)));
    assign off_last = (phase_cnt == ((cur_off == '0) ? '0 : cur_off - CNT_W'(1)));

    // Next state: abort, then completion, then pre-emption, then normal phase sequencing.
    always_comb begin
        nstate    = state;
        start_pat = 1'b0;
        next_beep = 1'b0;
        complete  = 1'b0;
        if (state == ST_IDLE) begin
            if (any_elig) begin
                nstate    = ST_ON;
                start_pat = 1'b1;
            end
        end else if (!cur_req) begin
            nstate    = any_elig ? ST_ON : ST_IDLE;
            start_pat = any_elig;
        end else if ((state == ST_OFF) && off_last && (cur_rep != '0) && (beep_cnt == cur_rep)) begin
            nstate   = ST_IDLE;
            complete = 1'b1;
        end else if (winner > active_src) begin
            nstate    = ST_ON;
            start_pat = 1'b1;
        end else if ((state == ST_ON) && on_last) begin
            nstate = ST_OFF;
        end else if ((state == ST_OFF) && off_last) begin
            nstate    = ST_ON;
            next_beep = 1'b1;
        end
    end

    // State, source selection and phase/beep counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            active_src <= '0;
            phase_cnt  <= '0;
            beep_cnt   <= '0;
        end else begin
            state <= nstate;
            if (start_pat) begin
                active_src <= winner;
                phase_cnt  <= '0;
                beep_cnt   <= '0;
            end else if (next_beep || (nstate == ST_IDLE)) begin
                phase_cnt <= '0;
            end else if ((state == ST_ON) && (nstate == ST_OFF)) begin
                phase_cnt <= '0;
                if (beep_cnt != '1) begin
                    beep_cnt <= beep_cnt + REP_W'(1);
                end
            end else begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cmpl_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cmpl_vec[i] = complete && (active_src == SEL_W'(i));
        end
    end

    // Completion pulses and the served latch, which only releases when the request drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done   <= '0;
            served <= '0;
        end else begin
            done   <= cmpl_vec;
            served <= (served | cmpl_vec) & req;
        end
    end

`ifdef TONE_ARBITER_TWO_TONE_EN
    localparam int ALT_W = $clog2(ALT_CYCLES + 1);

    logic [ALT_W-1:0] alt_cnt;
    logic             alt_sel;
    logic [DIV_W-1:0] cur_alt;
    logic             swap;

    always_comb begin
        cur_alt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (active_src == SEL_W'(i)) begin
                cur_alt = alt_half_period[i*DIV_W +: DIV_W];
            end
        end
    end

    assign swap = (state == ST_ON) && !start_pat && !next_beep && (cur_alt != '0)
                  && (alt_cnt == ALT_W'(ALT_CYCLES - 1));

    // Warble timer: restarts on every ON entry, flips the divider target every ALT_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alt_cnt <= '0;
            alt_sel <= 1'b0;
        end else if (start_pat || next_beep) begin
            alt_cnt <= '0;
            alt_sel <= 1'b0;
        end else if (state == ST_ON) begin
            if (alt_cnt == ALT_W'(ALT_CYCLES - 1)) begin
                alt_cnt <= '0;
                alt_sel <= ~alt_sel;
            end else begin
                alt_cnt <= alt_cnt + ALT_W'(1);
            end
        end
    end

    assign div_target = (alt_sel && (cur_alt != '0)) ? cur_alt : cur_hp;
    assign div_clear  = (nstate != ST_ON) || start_pat || next_beep || swap;
`else
    assign div_target = cur_hp;
    assign div_clear  = (nstate != ST_ON) || start_pat || next_beep;
`endif

    tone_div #(
        .DIV_W(DIV_W)
    ) u_tone_div (
        .clk         (clk),
        .reset       (reset),
        .clear       (div_clear),
        .enable      (state == ST_ON),
        .half_period (div_target),
        .tone        (tone)
    );

    // Registered pin drive: silent outside ON, when muted, or for a zero half period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buzzer <= 1'b0;
        end else begin
            buzzer <= (state == ST_ON) && tone && !mute && (cur_hp != '0);
        end
    end

endmodule
